// File: rtl/game_sequencer_if.sv
// Board-store bus between the game sequencer (master) and the two-board cell memory (slave).
interface game_sequencer_if;
   // query_xy/query_sel are held by the master; cell_code answers them one cycle later.
   // wr_en is a single-cycle strobe qualifying wr_xy/wr_sel/wr_code, board_clr wipes both boards.
   logic [5:0] query_xy;
   logic       query_sel;
   logic [1:0] cell_code;
   logic       wr_en;
   logic [5:0] wr_xy;
   logic       wr_sel;
   logic [1:0] wr_code;
   logic       board_clr;

   modport master (
      output query_xy, query_sel, wr_en, wr_xy, wr_sel, wr_code, board_clr,
      input  cell_code
   );

   modport slave (
      input  query_xy, query_sel, wr_en, wr_xy, wr_sel, wr_code, board_clr,
      output cell_code
   );
endinterface

// File: rtl/game_sequencer.sv
// Battleship game-flow controller: ship placement, alternating fire turns, hit scoring,
// per-turn timeout and winner decision, driving a two-board cell store.
module game_sequencer #(
   parameter int SHIP_CELLS   = 4,
   parameter int TURN_TIMEOUT = 100_000_000,
   parameter int TO_W         = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_game,
   input  logic             click,
   input  logic [5:0]       mouse_pos,
   game_sequencer_if.master bus,
   output logic             turn,
   output logic [2:0]       host_hits,
   output logic [2:0]       guest_hits,
   output logic             game_over,
   output logic             winner,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      H_PLACE = 3'd1,
      G_PLACE = 3'd2,
      H_TURN  = 3'd3,
      G_TURN  = 3'd4,
      CHECK   = 3'd5,
      DECIDE  = 3'd6,
      OVER    = 3'd7
   } state_t;

   localparam logic [2:0]      SHIPS   = 3'(SHIP_CELLS);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TURN_TIMEOUT - 1);

   state_t          cur_q, nxt, origin_q, origin_d;
   logic [5:0]      qxy_q, qxy_d;
   logic            qsel_q, qsel_d;
   logic [2:0]      place_q, place_d, hh_q, hh_d, gh_q, gh_d;
   logic            turn_q, turn_d, win_q, win_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            clr_q, clr_d;
   logic            pend_en_q, pend_en_d;
   logic [1:0]      pend_code_q, pend_code_d;
   logic            wr_en_q, wr_sel_q;
   logic [5:0]      wr_xy_q;
   logic [1:0]      wr_code_q;

   logic [2:0] row, col, new_place, shooter_hits, new_hits;
   logic       in_grid, waiting, accept, shooter;

   assign row          = mouse_pos[5:3];
   assign col          = mouse_pos[2:0];
   assign in_grid      = ({1'b0, row} <= 4'd8) && ({1'b0, col} <= 4'd8);
   assign waiting      = cur_q inside {H_PLACE, G_PLACE, H_TURN, G_TURN};
   assign accept       = waiting && click && in_grid;
   assign shooter      = (origin_q == G_TURN);
   assign shooter_hits = shooter ? gh_q : hh_q;
   assign new_hits     = (shooter_hits < SHIPS) ? shooter_hits + 3'd1 : shooter_hits;
   assign new_place    = place_q + 3'd1;

   always_comb begin
      nxt         = cur_q;
      origin_d    = origin_q;
      qxy_d       = qxy_q;
      qsel_d      = qsel_q;
      place_d     = place_q;
      hh_d        = hh_q;
      gh_d        = gh_q;
      turn_d      = turn_q;
      win_d       = win_q;
      to_d        = '0;
      clr_d       = 1'b0;
      pend_en_d   = 1'b0;
      pend_code_d = 2'b00;
      case (cur_q)
         IDLE, OVER: begin
            if (start_game) begin
               clr_d   = 1'b1;
               nxt     = H_PLACE;
               place_d = 3'd0;
               hh_d    = 3'd0;
               gh_d    = 3'd0;
               turn_d  = 1'b0;
               win_d   = 1'b0;
            end
         end
         H_PLACE, G_PLACE, H_TURN, G_TURN: begin
            // An accepted click beats a timeout expiring on the same edge.
            if (accept) begin
               nxt      = CHECK;
               origin_d = cur_q;
               qxy_d    = mouse_pos;
               qsel_d   = (cur_q == G_PLACE) || (cur_q == H_TURN);
            end else if (cur_q == H_TURN || cur_q == G_TURN) begin
               if (to_q == TO_LAST) begin
                  turn_d = ~turn_q;
                  nxt    = (cur_q == H_TURN) ? G_TURN : H_TURN;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
         end
         CHECK: nxt = DECIDE;
         DECIDE: begin
            nxt = origin_q;
            if (origin_q == H_PLACE || origin_q == G_PLACE) begin
               if (bus.cell_code == 2'b00) begin
                  pend_en_d   = 1'b1;
                  pend_code_d = 2'b01;
                  if (new_place == SHIPS) begin
                     place_d = 3'd0;
                     turn_d  = 1'b0;
                     nxt     = (origin_q == H_PLACE) ? G_PLACE : H_TURN;
                  end else begin
                     place_d = new_place;
                  end
               end
            end else begin
               case (bus.cell_code)
                  2'b01: begin
                     pend_en_d   = 1'b1;
                     pend_code_d = 2'b10;
                     if (shooter) gh_d = new_hits;
                     else         hh_d = new_hits;
                     if (new_hits == SHIPS) begin
                        nxt   = OVER;
                        win_d = shooter;
                     end else begin
                        turn_d = ~shooter;
                        nxt    = shooter ? H_TURN : G_TURN;
                     end
                  end
                  2'b00: begin
                     pend_en_d   = 1'b1;
                     pend_code_d = 2'b11;
                     turn_d      = ~shooter;
                     nxt         = shooter ? H_TURN : G_TURN;
                  end
                  default: ;
               endcase
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur_q       <= IDLE;
         origin_q    <= IDLE;
         qxy_q       <= 6'd0;
         qsel_q      <= 1'b0;
         place_q     <= 3'd0;
         hh_q        <= 3'd0;
         gh_q        <= 3'd0;
         turn_q      <= 1'b0;
         win_q       <= 1'b0;
         to_q        <= '0;
         clr_q       <= 1'b0;
         pend_en_q   <= 1'b0;
         pend_code_q <= 2'b00;
         wr_en_q     <= 1'b0;
         wr_xy_q     <= 6'd0;
         wr_sel_q    <= 1'b0;
         wr_code_q   <= 2'b00;
      end else begin
         cur_q       <= nxt;
         origin_q    <= origin_d;
         qxy_q       <= qxy_d;
         qsel_q      <= qsel_d;
         place_q     <= place_d;
         hh_q        <= hh_d;
         gh_q        <= gh_d;
         turn_q      <= turn_d;
         win_q       <= win_d;
         to_q        <= to_d;
         clr_q       <= clr_d;
         pend_en_q   <= pend_en_d;
         pend_code_q <= pend_code_d;
         wr_en_q     <= pend_en_q;
         // query registers still hold the decided cell on this edge
         if (pend_en_q) begin
            wr_xy_q   <= qxy_q;
            wr_sel_q  <= qsel_q;
            wr_code_q <= pend_code_q;
         end
      end
   end

   assign bus.query_xy  = qxy_q;
   assign bus.query_sel = qsel_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_xy     = wr_xy_q;
   assign bus.wr_sel    = wr_sel_q;
   assign bus.wr_code   = wr_code_q;
   assign bus.board_clr = clr_q;
   assign turn          = turn_q;
   assign host_hits     = hh_q;
   assign guest_hits    = gh_q;
   assign game_over     = (cur_q == OVER);
   assign winner        = win_q;
   assign state         = cur_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed-plus-random bench for game_sequencer with a board memory and a rule-level game model.
module tb_game_sequencer;
   localparam int SHIPS = 4;
   localparam int TO    = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_game;
   logic       click;
   logic [5:0] mouse_pos;
   logic       turn;
   logic [2:0] host_hits;
   logic [2:0] guest_hits;
   logic       game_over;
   logic       winner;
   logic [2:0] state;

   game_sequencer_if bus ();

   game_sequencer #(.SHIP_CELLS(SHIPS), .TURN_TIMEOUT(TO), .TO_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_game (start_game),
      .click      (click),
      .mouse_pos  (mouse_pos),
      .bus        (bus),
      .turn       (turn),
      .host_hits  (host_hits),
      .guest_hits (guest_hits),
      .game_over  (game_over),
      .winner     (winner),
      .state      (state)
   );

   always #5 clk = ~clk;

   // board store: registered readback, write strobe, clear pulse
   logic [1:0] brd [2][64];
   always @(posedge clk) begin
      if (bus.board_clr) begin
         for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) brd[s][i] <= 2'b00;
      end else if (bus.wr_en) begin
         brd[bus.wr_sel][bus.wr_xy] <= bus.wr_code;
      end
      bus.cell_code <= brd[bus.query_sel][bus.query_xy];
   end

   int n_tests = 0;
   int n_fail  = 0;

   // game model: phase uses the visible state numbering (1/2 placement, 3/4 turns, 7 over)
   int         m_phase;
   bit         m_turn;
   bit         m_win;
   int         m_hh, m_gh, m_placed;
   logic [1:0] m_brd [2][64];
   logic [5:0] m_gship [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 64; i++) m_brd[s][i] = 2'b00;
      m_gship.delete();
      m_phase = 1; m_turn = 0; m_win = 0; m_hh = 0; m_gh = 0; m_placed = 0;
   endtask

   function automatic logic [5:0] pick_empty(input bit sel);
      logic [5:0] p;
      for (int k = 0; k < 1000; k++) begin
         p = 6'($urandom_range(0, 63));
         if (m_brd[sel][p] == 2'b00) return p;
      end
      return 6'o77;
   endfunction

   task automatic start(input bit with_click);
      start_game = 1'b1;
      click      = with_click;
      mouse_pos  = 6'($urandom_range(0, 63));
      tick();
      start_game = 1'b0;
      click      = 1'b0;
      model_clear();
      chk("start_clr", bus.board_clr, 1);
      chk("start_state", state, 1);
      chk("start_hh", host_hits, 0);
      chk("start_gh", guest_hits, 0);
      chk("start_turn", turn, 0);
      chk("start_over", game_over, 0);
      tick();
      chk("start_clr_pulse", bus.board_clr, 0);
      chk("start_click_dropped", state, 1);
      chk("start_no_wr", bus.wr_en, 0);
   endtask

   task automatic flip_turn();
      m_turn  = ~m_turn;
      m_phase = m_turn ? 4 : 3;
   endtask

   // one accepted click, checked through CHECK, DECIDE and the write strobe
   task automatic click_cell(input logic [5:0] pos, input bit spam);
      bit         sel, exp_en, t0, shooter;
      logic [1:0] code, exp_code;
      sel      = (m_phase == 2) || (m_phase == 3);
      code     = m_brd[sel][pos];
      exp_en   = 0;
      exp_code = 2'b00;
      t0       = m_turn;
      if (m_phase == 1 || m_phase == 2) begin
         if (code == 2'b00) begin
            exp_en = 1; exp_code = 2'b01; m_placed++;
            if (sel) m_gship.push_back(pos);
            if (m_placed == SHIPS) begin
               m_placed = 0; m_turn = 0;
               m_phase  = (m_phase == 1) ? 2 : 3;
            end
         end
      end else begin
         shooter = (m_phase == 4);
         if (code == 2'b01) begin
            exp_en = 1; exp_code = 2'b10;
            if (shooter) m_gh++; else m_hh++;
            if ((shooter ? m_gh : m_hh) == SHIPS) begin
               m_phase = 7; m_win = shooter;
            end else flip_turn();
         end else if (code == 2'b00) begin
            exp_en = 1; exp_code = 2'b11;
            flip_turn();
         end
      end
      if (exp_en) m_brd[sel][pos] = exp_code;

      click = 1'b1; mouse_pos = pos;
      tick();
      if (spam) mouse_pos = 6'($urandom_range(0, 63));
      else      click = 1'b0;
      chk("acc_state", state, 5);
      chk("acc_qxy", bus.query_xy, pos);
      chk("acc_qsel", bus.query_sel, sel);
      chk("acc_turn_hold", turn, t0);
      chk("acc_no_wr", bus.wr_en, 0);
      tick();
      chk("chk_state", state, 6);
      chk("chk_no_wr", bus.wr_en, 0);
      tick();
      click = 1'b0;
      chk("dec_no_wr", bus.wr_en, 0);
      chk("dec_state", state, m_phase);
      chk("dec_hh", host_hits, m_hh);
      chk("dec_gh", guest_hits, m_gh);
      chk("dec_over", game_over, m_phase == 7);
      if (m_phase == 7) chk("dec_winner", winner, m_win);
      else              chk("dec_turn", turn, m_turn);
      tick();
      chk("wr_en", bus.wr_en, exp_en);
      if (exp_en) begin
         chk("wr_xy", bus.wr_xy, pos);
         chk("wr_sel", bus.wr_sel, sel);
         chk("wr_code", bus.wr_code, exp_code);
      end
   endtask

   // entered with the turn counter at 1 (just after a click returned)
   task automatic idle_flip();
      for (int i = 0; i < TO - 2; i++) begin
         tick();
         chk("to_turn_hold", turn, m_turn);
         chk("to_no_wr", bus.wr_en, 0);
      end
      tick();
      flip_turn();
      chk("to_turn_flip", turn, m_turn);
      chk("to_state", state, m_phase);
      chk("to_flip_no_wr", bus.wr_en, 0);
   endtask

   initial begin
      logic [5:0] p;
      int         g;
      rst = 1'b0; start_game = 1'b0; click = 1'b0; mouse_pos = 6'd0;
      model_clear();
      repeat (3) tick();
      chk("rst_state", state, 0);
      chk("rst_turn", turn, 0);
      chk("rst_hh", host_hits, 0);
      chk("rst_gh", guest_hits, 0);
      chk("rst_over", game_over, 0);
      chk("rst_winner", winner, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_clr", bus.board_clr, 0);
      chk("rst_qxy", bus.query_xy, 0);
      rst = 1'b1;
      click = 1'b1; mouse_pos = 6'o11;
      tick();
      click = 1'b0;
      chk("idle_click_ignored", state, 0);

      // directed game, host wins
      start(1'b0);
      click_cell(6'o00, 1'b0);
      click_cell(6'o00, 1'b0);
      start_game = 1'b1;
      tick();
      start_game = 1'b0;
      chk("start_ignored_clr", bus.board_clr, 0);
      chk("start_ignored_state", state, 1);
      g = 0;
      while (m_phase == 1 && g < 100) begin
         click_cell(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
         g++;
      end
      chk("host_place_done", state, 2);
      click_cell(6'o23, 1'b1);
      click_cell(6'o45, 1'b0);
      click_cell(6'o67, 1'b0);
      click_cell(6'o12, 1'b0);
      chk("guest_place_done", state, 3);
      chk("first_turn", turn, 0);
      idle_flip();
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         chk("pre_expiry_turn", turn, 1);
      end
      click_cell(pick_empty(1'b0), 1'b0);
      click_cell(6'o23, 1'b0);
      click_cell(pick_empty(1'b0), 1'b0);
      click_cell(6'o23, 1'b0);
      click_cell(6'o71, 1'b0);
      click_cell(pick_empty(1'b0), 1'b0);
      click_cell(6'o45, 1'b0);
      click_cell(pick_empty(1'b0), 1'b0);
      click_cell(6'o67, 1'b0);
      click_cell(pick_empty(1'b0), 1'b0);
      click_cell(6'o12, 1'b0);
      chk("over_state", state, 7);
      chk("over_flag", game_over, 1);
      chk("over_winner", winner, 0);
      chk("over_hh", host_hits, 4);
      click = 1'b1; mouse_pos = 6'o33;
      tick();
      click = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("over_click_ignored", state, 7);
         chk("over_no_wr", bus.wr_en, 0);
         chk("over_hold", game_over, 1);
      end

      // random game
      start(1'b1);
      g = 0;
      while (m_phase != 7 && g < 400) begin
         if (m_phase == 3 && $urandom_range(0, 1) == 1)
            p = m_gship[$urandom_range(0, m_gship.size() - 1)];
         else
            p = 6'($urandom_range(0, 63));
         click_cell(p, ($urandom_range(0, 3) == 0));
         g++;
      end
      chk("rand_game_end", state, 7);

      // reset while DECIDE holds a pending write
      start(1'b0);
      click = 1'b1; mouse_pos = pick_empty(1'b0);
      tick();
      click = 1'b0;
      chk("rstd_check", state, 5);
      tick();
      chk("rstd_decide", state, 6);
      rst = 1'b0;
      tick();
      chk("rstd_no_wr", bus.wr_en, 0);
      chk("rstd_state", state, 0);
      chk("rstd_qxy", bus.query_xy, 0);
      rst = 1'b1;
      tick();
      chk("rstd_no_wr_after", bus.wr_en, 0);
      chk("rstd_idle", state, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
